// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: standard VGA mode timings ({active, front porch, sync, back porch}) and axis helpers.
package vga_timing_pkg;
  localparam int MODE_640X480_60_H[4] = '{640, 16, 96, 48};
  localparam int MODE_640X480_60_V[4] = '{480, 10, 2, 33};
  localparam int MODE_640X480_72_H[4] = '{640, 24, 40, 128};
  localparam int MODE_640X480_72_V[4] = '{480, 9, 3, 28};
  localparam int MODE_800X600_60_H[4] = '{800, 40, 128, 88};
  localparam int MODE_800X600_60_V[4] = '{600, 1, 4, 23};
  function automatic int axis_total(int active, int fp, int sync, int bp);
    return active + fp + sync + bp;
  endfunction
endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis; active-first ordering, then front porch, sync, back porch.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int   ACTIVE = 640,
  parameter int   FP     = 24,
  parameter int   SYNC   = 40,
  parameter int   BP     = 128,
  parameter logic POL    = 1'b0,
  parameter int   CW     = 11
) (
  input  logic          px_clk,
  input  logic          reset,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          wrap,
  output logic          active,
  output logic          sync
);
  localparam int TOT = axis_total(ACTIVE, FP, SYNC, BP);
  assign wrap   = count == CW'(TOT - 1);
  assign active = count < CW'(ACTIVE);
  assign sync   = (count >= CW'(ACTIVE + FP) && count < CW'(ACTIVE + FP + SYNC)) ? POL : ~POL;
  always_ff @(posedge px_clk or posedge reset)
    if (reset) count <= '0;
    else if (inc) count <= wrap ? '0 : count + CW'(1);
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing with registered, mutually aligned sync/video/strobe outputs.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   CW       = 11,
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 24,
  parameter int   H_SYNC   = 40,
  parameter int   H_BP     = 128,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 9,
  parameter int   V_SYNC   = 3,
  parameter int   V_BP     = 28,
  parameter logic H_POL    = 1'b0,
  parameter logic V_POL    = 1'b0
) (
  input  logic          px_clk,
  input  logic          reset,
  input  logic          ce,
  output logic          hsync,
  output logic          vsync,
  output logic          activevideo,
  output logic [CW-1:0] x_px,
  output logic [CW-1:0] y_px,
  output logic          line_start,
  output logic          frame_start
);
  localparam int H_TOT = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOT = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
      H_TOT > 2**CW || V_TOT > 2**CW) begin : g_bad_params
    $error("vga_timing_gen: zero timing parameter or axis total exceeds 2**CW");
  end
  logic [CW-1:0] hc, vc;
  logic h_wrap, h_act, h_sync, v_act, v_sync, unused_v_wrap, vis;
  vga_axis_counter #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(H_POL), .CW(CW)) u_h (
    .px_clk(px_clk), .reset(reset), .inc(ce), .count(hc), .wrap(h_wrap), .active(h_act), .sync(h_sync)
  );
  vga_axis_counter #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(V_POL), .CW(CW)) u_v (
    .px_clk(px_clk), .reset(reset), .inc(ce && h_wrap), .count(vc), .wrap(unused_v_wrap),
    .active(v_act), .sync(v_sync)
  );
  assign vis = h_act && v_act;
  always_ff @(posedge px_clk or posedge reset)
    if (reset) begin
      hsync       <= ~H_POL;
      vsync       <= ~V_POL;
      activevideo <= 1'b0;
      x_px        <= '0;
      y_px        <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (ce) begin
      hsync       <= h_sync;
      vsync       <= v_sync;
      activevideo <= vis;
      x_px        <= vis ? hc : '0;
      y_px        <= vis ? vc : '0;
      line_start  <= hc == '0;
      frame_start <= hc == '0 && vc == '0;
    end
endmodule
